// File: rtl/config_loader_if.sv
// Word-stream handshake between a configuration source and config_loader.
// The source drives word_in/word_valid; the loader answers with word_ready.
interface config_loader_if #(
    parameter int WORD_WIDTH = 32
);
    logic [WORD_WIDTH-1:0] word_in;
    logic                  word_valid;
    logic                  word_ready;

    modport master (
        output word_in,
        output word_valid,
        input  word_ready
    );

    modport slave (
        input  word_in,
        input  word_valid,
        output word_ready
    );
endinterface

// File: rtl/config_loader.sv
// Streams configuration words into a wide registered bus for a logic grid,
// holding the grid in reset until the whole bus has settled.
module config_loader #(
    parameter  int CONFIG_WIDTH = 1314,
    parameter  int WORD_WIDTH   = 32,
    localparam int NUM_WORDS    = (CONFIG_WIDTH + WORD_WIDTH - 1) / WORD_WIDTH,
    localparam int CW           = $clog2(NUM_WORDS + 1)
) (
    input  logic                    clock,
    input  logic                    nreset,
    input  logic                    start,
    config_loader_if.slave          bus,
    output logic [CONFIG_WIDTH-1:0] config_out,
    output logic                    grid_nreset,
    output logic                    busy,
    output logic                    done,
    output logic [CW-1:0]           words_loaded
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SETTLE,
        RUN
    } state_t;

    localparam logic [CW-1:0] LAST = CW'(NUM_WORDS - 1);
    localparam logic [CW-1:0] FULL = CW'(NUM_WORDS);

    state_t                  state_q;
    state_t                  state_d;
    logic [CONFIG_WIDTH-1:0] cfg_d;
    logic [CW-1:0]           cnt_d;
    logic                    ready_q;
    logic                    accept;

    // A start in the same cycle as a handshake restarts the load and drops the word.
    assign accept         = ready_q & bus.word_valid & ~start;
    assign bus.word_ready = ready_q;

    always_comb begin
        state_d = state_q;
        cfg_d   = config_out;
        cnt_d   = words_loaded;
        unique case (state_q)
            IDLE, RUN: begin
                if (start) begin
                    state_d = LOAD;
                    cfg_d   = '0;
                    cnt_d   = '0;
                end
            end
            LOAD: begin
                if (start) begin
                    cfg_d = '0;
                    cnt_d = '0;
                end else if (accept) begin
                    // Bits of the final word beyond CONFIG_WIDTH fall off here.
                    for (int i = 0; i < CONFIG_WIDTH; i++) begin
                        if (CW'(i / WORD_WIDTH) == words_loaded) begin
                            cfg_d[i] = bus.word_in[i % WORD_WIDTH];
                        end
                    end
                    if (words_loaded != FULL) begin
                        cnt_d = words_loaded + 1'b1;
                    end
                    if (words_loaded == LAST) begin
                        state_d = SETTLE;
                    end
                end
            end
            SETTLE: state_d = RUN;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            state_q      <= IDLE;
            config_out   <= '0;
            words_loaded <= '0;
            ready_q      <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            grid_nreset  <= 1'b0;
        end else begin
            state_q      <= state_d;
            config_out   <= cfg_d;
            words_loaded <= cnt_d;
            ready_q      <= (state_d == LOAD);
            busy         <= (state_d == LOAD) || (state_d == SETTLE);
            done         <= (state_d == RUN);
            grid_nreset  <= (state_d == RUN);
        end
    end

endmodule

// File: tb/tb_config_loader.sv
// Self-checking bench for config_loader: vector table, directed corner
// sequences and random traffic against a word-array reference model.
module tb_config_loader;

    localparam int CFGW = 1314;
    localparam int WW   = 32;
    localparam int NW   = 42;
    localparam int CW   = 6;

    logic            clock = 1'b0;
    logic            nreset;
    logic            start;
    logic [CFGW-1:0] config_out;
    logic            grid_nreset;
    logic            busy;
    logic            done;
    logic [CW-1:0]   words_loaded;

    config_loader_if #(.WORD_WIDTH(WW)) bus ();

    config_loader #(
        .CONFIG_WIDTH(CFGW),
        .WORD_WIDTH  (WW)
    ) dut (
        .clock       (clock),
        .nreset      (nreset),
        .start       (start),
        .bus         (bus),
        .config_out  (config_out),
        .grid_nreset (grid_nreset),
        .busy        (busy),
        .done        (done),
        .words_loaded(words_loaded)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    // Reference model: which phase we are in, and the words written so far.
    int          m_cnt;
    bit          m_loading;
    bit          m_settling;
    bit          m_running;
    logic [31:0] m_words[NW];

    task automatic model_reset();
        m_cnt      = 0;
        m_loading  = 0;
        m_settling = 0;
        m_running  = 0;
        for (int k = 0; k < NW; k++) m_words[k] = '0;
    endtask

    task automatic model_step(bit s, bit v, logic [31:0] w);
        if (s && !m_settling) begin
            m_loading = 1;
            m_running = 0;
            m_cnt     = 0;
            for (int k = 0; k < NW; k++) m_words[k] = '0;
        end else if (m_loading && v) begin
            m_words[m_cnt] = w;
            m_cnt++;
            if (m_cnt == NW) begin
                m_loading  = 0;
                m_settling = 1;
            end
        end else if (m_settling) begin
            m_settling = 0;
            m_running  = 1;
        end
    endtask

    function automatic logic [CFGW-1:0] model_cfg();
        logic [NW*WW-1:0] p = '0;
        for (int k = 0; k < NW; k++) p[k*WW +: WW] = m_words[k];
        return p[CFGW-1:0];
    endfunction

    // Configuration expected after loading words k+1 for k = 0..NW-1.
    function automatic logic [CFGW-1:0] ramp_cfg();
        logic [NW*WW-1:0] p = '0;
        for (int k = 0; k < NW; k++) p[k*WW +: WW] = 32'(k + 1);
        return p[CFGW-1:0];
    endfunction

    task automatic check(string name, longint got, longint exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic check_cfg(string name, logic [CFGW-1:0] exp);
        logic [NW*WW-1:0] g = '0;
        logic [NW*WW-1:0] e = '0;
        total++;
        if (config_out !== exp) begin
            bad++;
            g[CFGW-1:0] = config_out;
            e[CFGW-1:0] = exp;
            for (int k = 0; k < NW; k++) begin
                if (g[k*WW +: WW] !== e[k*WW +: WW]) begin
                    $display("FAIL %s config word %0d: got %h expected %h",
                             name, k, g[k*WW +: WW], e[k*WW +: WW]);
                    break;
                end
            end
        end
    endtask

    task automatic check_all(string tag);
        check({tag, " ready"}, bus.word_ready, m_loading);
        check({tag, " busy"}, busy, m_loading | m_settling);
        check({tag, " done"}, done, m_running);
        check({tag, " grid_nreset"}, grid_nreset, m_running);
        check({tag, " words_loaded"}, words_loaded, m_cnt);
        check_cfg(tag, model_cfg());
    endtask

    task automatic cycle(string tag, bit s, bit v, logic [31:0] w);
        start          = s;
        bus.word_valid = v;
        bus.word_in    = w;
        @(posedge clock);
        model_step(s, v, w);
        #1;
        check_all(tag);
    endtask

    task automatic do_reset(string tag);
        nreset = 1'b0;
        #2;
        model_reset();
        check_all(tag);
        check({tag, " async cfg zero"}, (config_out == '0), 1);
        @(posedge clock);
        #1;
        nreset = 1'b1;
    endtask

    // Full load of words k+1; optional idle cycle between words, optional
    // start pulse during the settle cycle (which must be ignored).
    task automatic load_ramp(string tag, bit gaps, bit start_in_settle);
        cycle({tag, " start"}, 1, 0, 0);
        for (int k = 0; k < NW; k++) begin
            cycle({tag, " word"}, 0, 1, 32'(k + 1));
            check({tag, " count"}, words_loaded, k + 1);
            if (gaps && k != NW - 1) begin
                cycle({tag, " gap"}, 0, 0, $urandom);
                check({tag, " gap count"}, words_loaded, k + 1);
            end
        end
        check({tag, " settle busy"}, busy, 1);
        check({tag, " settle done"}, done, 0);
        check({tag, " settle grid"}, grid_nreset, 0);
        check({tag, " settle ready"}, bus.word_ready, 0);
        cycle({tag, " settle"}, start_in_settle, 1, $urandom);
        check({tag, " run done"}, done, 1);
        check({tag, " run grid"}, grid_nreset, 1);
        check({tag, " run count"}, words_loaded, NW);
        check_cfg({tag, " run cfg"}, ramp_cfg());
    endtask

    typedef struct {
        bit          s;
        bit          v;
        logic [31:0] w;
        int          cnt;
        bit          rdy;
        logic [31:0] w0;
    } vec_t;

    vec_t tbl[8];

    initial begin
        tbl[0] = '{s: 0, v: 1, w: 32'hAA, cnt: 0, rdy: 0, w0: 32'h0};
        tbl[1] = '{s: 1, v: 1, w: 32'hBB, cnt: 0, rdy: 1, w0: 32'h0};
        tbl[2] = '{s: 0, v: 1, w: 32'h11, cnt: 1, rdy: 1, w0: 32'h11};
        tbl[3] = '{s: 0, v: 0, w: 32'h99, cnt: 1, rdy: 1, w0: 32'h11};
        tbl[4] = '{s: 0, v: 1, w: 32'h22, cnt: 2, rdy: 1, w0: 32'h11};
        tbl[5] = '{s: 1, v: 1, w: 32'h33, cnt: 0, rdy: 1, w0: 32'h0};
        tbl[6] = '{s: 0, v: 1, w: 32'h44, cnt: 1, rdy: 1, w0: 32'h44};
        tbl[7] = '{s: 0, v: 0, w: 32'h55, cnt: 1, rdy: 1, w0: 32'h44};

        nreset         = 1'b0;
        start          = 1'b0;
        bus.word_valid = 1'b0;
        bus.word_in    = '0;
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        check_all("reset");
        nreset = 1'b1;

        for (int i = 0; i < 10; i++) cycle("idle", 0, 0, 0);
        check("idle grid", grid_nreset, 0);
        check("idle ready", bus.word_ready, 0);
        check("idle done", done, 0);
        check_cfg("idle cfg", '0);

        for (int i = 0; i < 8; i++) begin
            cycle("tbl", tbl[i].s, tbl[i].v, tbl[i].w);
            check($sformatf("tbl%0d count", i), words_loaded, tbl[i].cnt);
            check($sformatf("tbl%0d ready", i), bus.word_ready, tbl[i].rdy);
            check($sformatf("tbl%0d w0", i), config_out[31:0], tbl[i].w0);
        end

        load_ramp("cont", 0, 0);
        check("cont w0", config_out[31:0], 1);
        check("cont w40", config_out[1311:1280], 41);
        check("cont top", config_out[1313:1312], 2'b10);
        for (int i = 0; i < 3; i++) cycle("run hold", 0, 1, $urandom);

        load_ramp("gaps", 1, 1);

        cycle("abort start", 1, 0, 0);
        for (int k = 0; k < 20; k++) cycle("abort word", 0, 1, 32'(k + 1));
        cycle("abort hit", 1, 1, 32'd21);
        check("abort count", words_loaded, 0);
        check_cfg("abort cfg", '0);
        check("abort ready", bus.word_ready, 1);
        load_ramp("after abort", 0, 0);

        cycle("mid start", 1, 0, 0);
        for (int k = 0; k < 30; k++) cycle("mid word", 0, 1, $urandom);
        do_reset("mid reset");
        for (int i = 0; i < 3; i++) begin
            cycle("post reset", 0, 1, $urandom);
            check("post reset ready", bus.word_ready, 0);
        end
        load_ramp("reload", 0, 0);

        cycle("run restart", 1, 1, 32'hDEAD_BEEF);
        check("restart grid", grid_nreset, 0);
        check_cfg("restart cfg", '0);
        check("restart ready", bus.word_ready, 1);
        check("restart count", words_loaded, 0);

        for (int i = 0; i < 600; i++) begin
            cycle("random", $urandom_range(0, 39) == 0,
                  $urandom_range(0, 3) != 0, $urandom);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
